// File: rtl/inst_fetch.sv
// RV32I instruction fetch stage: owns the fetch PC and issues in-order word reads.
// Buffers {inst, pc} for decode; optional FETCH_MISALIGN_TRAP_EN flags misaligned redirects.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        if_misalign
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        STALL
    } state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];

    logic             req_fire;
    logic             push;
    logic             pop;
    logic             misalign_redirect;
    logic [CNT_W:0]   in_use;
    logic [CNT_W-1:0] out_next;
    logic [CNT_W-1:0] drop_next;
    logic [31:0]      target;

    // Both channels use valid/ready: a transfer happens on the rising edge where valid
    // and ready are both high; a pending request holds addr stable until it transfers.
    assign in_use         = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = rst_n && !redirect_valid && (state == FETCH) && (in_use < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push   = imem_resp_valid && (drop_cnt == '0) && !redirect_valid && (state == FETCH);
    assign pop    = if_valid && if_ready;
    assign target = redirect_pc & ~32'd3;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign misalign_redirect = 1'b0;
`endif

    // A response arriving in a redirect cycle is already counted out of out_next.
    assign out_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

    always_comb begin
        drop_next = drop_cnt;
        if (redirect_valid) begin
            drop_next = out_next;
        end else if (imem_resp_valid && (drop_cnt != '0)) begin
            drop_next = drop_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= out_next;
            drop_cnt    <= drop_next;
            if (redirect_valid) begin
                fetch_pc <= target;
                resp_pc  <= target;
                rd_ptr   <= '0;
                if (misalign_redirect) begin
                    count  <= CNT_W'(1);
                    wr_ptr <= PTR_W'(1);
                    state  <= STALL;
                end else begin
                    count  <= '0;
                    wr_ptr <= '0;
                    state  <= (drop_next != '0) ? DRAIN : FETCH;
                end
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
                if ((state == DRAIN) && (drop_next == '0)) begin
                    state <= FETCH;
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fifo_mis [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (misalign_redirect) begin
            fifo_mis[0] <= 1'b1;
        end else if (push) begin
            fifo_mis[wr_ptr] <= 1'b0;
        end
    end

    assign if_misalign = (count != '0) && fifo_mis[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (misalign_redirect) begin
            fifo_inst[0] <= NOP_INST;
            fifo_pc[0]   <= redirect_pc;
        end else if (push) begin
            fifo_inst[wr_ptr] <= imem_resp_data;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    assign if_valid = (count != '0);
    assign if_inst  = if_valid ? fifo_inst[rd_ptr] : NOP_INST;
    assign if_pc    = if_valid ? fifo_pc[rd_ptr] : 32'd0;

    // The credit rule bounds outstanding + buffered, so a push into a full FIFO is a bug.
    always_ff @(posedge clk) begin
        if (rst_n && push && !pop) begin
            assert (count < DEPTH_C[CNT_W-1:0]);
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: in-order memory model with random latency, and a queue model of
// the instruction stream decode should see (stale responses after redirects never appear).
module tb_inst_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif

    inst_fetch #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(DEPTH),
        .NOP_INST  (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
`ifdef FETCH_MISALIGN_TRAP_EN
        .if_pc          (if_pc),
        .if_misalign    (if_misalign)
`else
        .if_pc          (if_pc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    pend_t       pend_q[$];
    logic [64:0] exp_q[$];   // {misalign, pc, inst} of what decode should see, head first
    logic [31:0] exp_req_pc = 32'd0;
    bit          stalled = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          pops = 0;

    int          p_req_ready = 100;
    int          p_if_ready = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          p_redir = 0;
    bit          redir_now = 1'b0;
    bit          redir_on_resp = 1'b0;
    bit          redir_on_resp_hit = 1'b0;
    logic [31:0] redir_target = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit any_stale();
        foreach (pend_q[i]) if (pend_q[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        bit          resp;
        bit          redir;
        bit          exp_rv;
        bit          accept;
        logic [31:0] rpc;
        logic [64:0] head;
        pend_t       h;
        pend_t       n;
        @(negedge clk);
        cyc++;
        resp = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_word(pend_q[0].addr) : $urandom;
        imem_req_ready  = ($urandom_range(99) < p_req_ready);
        if_ready        = ($urandom_range(99) < p_if_ready);
        rpc = ($urandom & 32'h0000_0FFF);
        if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h3);
`ifdef FETCH_MISALIGN_TRAP_EN
        rpc = rpc & ~32'd3;
`endif
        redir = ($urandom_range(99) < p_redir);
        if (redir_on_resp && resp && exp_q.size() > 0) begin
            redir = 1'b1;
            if_ready = 1'b1;
            redir_on_resp = 1'b0;
            redir_on_resp_hit = 1'b1;
        end
        if (redir_now) begin
            redir = 1'b1;
            rpc = redir_target;
            redir_now = 1'b0;
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        exp_rv = !redir && !stalled && !any_stale() && ((pend_q.size() + exp_q.size()) < DEPTH);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
        check("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("if_pc", if_pc, head[63:32]);
            check("if_inst", if_inst, head[31:0]);
`ifdef FETCH_MISALIGN_TRAP_EN
            check("if_misalign", 32'(if_misalign), 32'(head[64]));
`endif
        end else begin
            check("empty_pc", if_pc, 32'd0);
            check("empty_inst", if_inst, NOP);
        end
        accept = imem_req_valid && imem_req_ready;
        if (resp) h = pend_q.pop_front();
        if (exp_q.size() != 0 && if_ready) begin
            void'(exp_q.pop_front());
            pops++;
        end
        if (redir) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_req_pc = rpc & ~32'd3;
            stalled = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) begin
                stalled = 1'b1;
                exp_q.push_back({1'b1, rpc, NOP});
            end
`endif
        end else if (resp && !h.stale && !stalled) begin
            exp_q.push_back({1'b0, h.addr, mem_word(h.addr)});
        end
        if (accept) begin
            n.addr  = imem_req_addr;
            n.due   = cyc + $urandom_range(lat_max, lat_min);
            n.stale = 1'b0;
            pend_q.push_back(n);
            exp_req_pc = exp_req_pc + 32'd4;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_inst", if_inst, NOP);
        check("rst_if_pc", if_pc, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_if_misalign", 32'(if_misalign), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // streaming with always-ready memory and decode
        pops = 0;
        run(30);
        total++;
        assert (pops >= 15) else begin
            bad++;
            $error("FAIL stream_progress observed=%0d expected>=15", pops);
        end

        // decode stalls, then releases
        p_if_ready = 0;
        run(10);
        p_if_ready = 100;
        run(10);

        // memory not ready for 3 cycles
        p_req_ready = 0;
        run(3);
        p_req_ready = 100;
        run(10);

        // latency 3, redirect with two requests in flight
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 20 && pend_q.size() < 2; i++) step();
        check("two_in_flight", pend_q.size(), 32'd2);
        redir_target = 32'h0000_0100;
        redir_now = 1'b1;
        run(15);

        // redirect coinciding with a response and a decode pop
        lat_min = 1;
        lat_max = 1;
        redir_on_resp = 1'b1;
        run(20);
        check("redir_on_resp_reached", 32'(redir_on_resp_hit), 32'd1);
        redir_on_resp = 1'b0;
        run(5);

`ifdef FETCH_MISALIGN_TRAP_EN
        redir_target = 32'h0000_0102;
        redir_now = 1'b1;
        p_if_ready = 0;
        run(6);
        p_if_ready = 100;
        run(4);
        redir_target = 32'h0000_0200;
        redir_now = 1'b1;
        run(20);
`endif

        // randomized traffic, knobs reshuffled every 50 cycles
        for (int blk = 0; blk < 12; blk++) begin
            p_req_ready = $urandom_range(100, 30);
            p_if_ready  = $urandom_range(100, 20);
            lat_min     = $urandom_range(2, 1);
            lat_max     = lat_min + $urandom_range(2, 0);
            p_redir     = $urandom_range(8, 0);
            run(50);
        end
        p_redir = 0;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end
endmodule
